spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_shift_engine_if.sv | 33 +++
 rtl/spi_shift_engine.sv | 129 ++++++++++++
 tb/tb_spi_shift_engine.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_if.sv
// Parallel-side bus of the SPI shift engine: frame control, baud strobes,
// serial pins and the receive result.
interface spi_shift_engine_if #(
   parameter int DW = 8,
   parameter int CW = $clog2(DW)
);
   logic          ss_i;
   logic          start_i;
   logic          cpha_i;
   logic          lsbfe_i;
   logic [CW-1:0] frame_len_i;
   logic          launch_i;
   logic          sample_i;
   logic [DW-1:0] data_mosi_i;
   logic          miso_i;
   logic          mosi_o;
   logic [DW-1:0] data_miso_o;
   logic          rx_valid_o;
   logic          busy_o;
   logic          abort_o;

   modport master (
      output ss_i, start_i, cpha_i, lsbfe_i, frame_len_i, launch_i, sample_i,
             data_mosi_i, miso_i,
      input  mosi_o, data_miso_o, rx_valid_o, busy_o, abort_o
   );

   modport slave (
      input  ss_i, start_i, cpha_i, lsbfe_i, frame_len_i, launch_i, sample_i,
             data_mosi_i, miso_i,
      output mosi_o, data_miso_o, rx_valid_o, busy_o, abort_o
   );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI shift engine: shifts one frame of up to DW bits out on mosi_o and in from
// miso_i, paced by external launch/sample strobes; slave select high aborts.
module spi_shift_engine #(
   parameter int DW = 8,
   parameter int CW = $clog2(DW)
) (
   input logic              PCLK,
   input logic              PRESET_n,
   spi_shift_engine_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] tx_q, tx_d;
   logic [DW-1:0] rx_q, rx_d;
   logic [DW-1:0] data_miso_q, data_miso_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW:0]   tx_idx_q, tx_idx_d;
   logic [CW:0]   cnt_q, cnt_d;
   logic          lsbfe_q, lsbfe_d;
   logic          mosi_q, mosi_d;
   logic          rx_valid_q, rx_valid_d;
   logic          abort_q, abort_d;

   logic [CW-1:0] len_eff, first_pos, tx_pos, rx_pos;
   logic [DW-1:0] rx_mask;

   always_comb begin
      len_eff   = (bus.frame_len_i > CW'(DW - 1)) ? CW'(DW - 1) : bus.frame_len_i;
      first_pos = bus.lsbfe_i ? '0 : len_eff;
      tx_pos    = lsbfe_q ? tx_idx_q[CW-1:0] : len_q - tx_idx_q[CW-1:0];
      rx_pos    = lsbfe_q ? cnt_q[CW-1:0] : len_q - cnt_q[CW-1:0];
      rx_mask   = '0;
      for (int i = 0; i < DW; i++) begin
         if (i <= int'(len_q)) rx_mask[i] = 1'b1;
      end

      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      data_miso_d = data_miso_q;
      len_d       = len_q;
      tx_idx_d    = tx_idx_q;
      cnt_d       = cnt_q;
      lsbfe_d     = lsbfe_q;
      mosi_d      = mosi_q;
      rx_valid_d  = 1'b0;
      abort_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i && !bus.ss_i) begin
               tx_d    = bus.data_mosi_i;
               rx_d    = '0;
               len_d   = len_eff;
               lsbfe_d = bus.lsbfe_i;
               cnt_d   = '0;
               state_d = SHIFT;
               // Clock phase only matters here: cpha=0 preloads the first bit,
               // so the launch pointer then starts one bit ahead.
               if (!bus.cpha_i) begin
                  mosi_d   = bus.data_mosi_i[first_pos];
                  tx_idx_d = {{CW{1'b0}}, 1'b1};
               end else begin
                  tx_idx_d = '0;
               end
            end
         end
         SHIFT: begin
            if (bus.ss_i) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               if (bus.launch_i && (tx_idx_q <= {1'b0, len_q})) begin
                  mosi_d   = tx_q[tx_pos];
                  tx_idx_d = tx_idx_q + 1'b1;
               end
               if (bus.sample_i) begin
                  rx_d[rx_pos] = bus.miso_i;
                  cnt_d        = cnt_q + 1'b1;
                  if (cnt_q == {1'b0, len_q}) begin
                     state_d     = DONE;
                     rx_valid_d  = 1'b1;
                     data_miso_d = rx_d & rx_mask;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         data_miso_q <= '0;
         len_q       <= '0;
         tx_idx_q    <= '0;
         cnt_q       <= '0;
         lsbfe_q     <= 1'b0;
         mosi_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         data_miso_q <= data_miso_d;
         len_q       <= len_d;
         tx_idx_q    <= tx_idx_d;
         cnt_q       <= cnt_d;
         lsbfe_q     <= lsbfe_d;
         mosi_q      <= mosi_d;
         rx_valid_q  <= rx_valid_d;
         abort_q     <= abort_d;
      end
   end

   assign bus.mosi_o      = mosi_q;
   assign bus.data_miso_o = data_miso_q;
   assign bus.rx_valid_o  = rx_valid_q;
   assign bus.busy_o      = (state_q == SHIFT);
   assign bus.abort_o     = abort_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: three widths (8, 12, 16) share one stimulus stream
// and are checked every cycle against a bit-count model of the frame rules.
module tb_spi_shift_engine;
   logic PCLK = 1'b0;
   logic PRESET_n = 1'b1;
   always #5 PCLK = ~PCLK;

   logic        ss = 1'b1, start = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
   logic        launch = 1'b0, sample = 1'b0, miso = 1'b0;
   logic [3:0]  fl = '0;
   logic [15:0] tx = '0;
   int total = 0;
   int bad = 0;

   spi_shift_engine_if #(.DW(8))  if8 ();
   spi_shift_engine_if #(.DW(12)) if12 ();
   spi_shift_engine_if #(.DW(16)) if16 ();

   spi_shift_engine #(.DW(8))  u8  (.PCLK(PCLK), .PRESET_n(PRESET_n), .bus(if8));
   spi_shift_engine #(.DW(12)) u12 (.PCLK(PCLK), .PRESET_n(PRESET_n), .bus(if12));
   spi_shift_engine #(.DW(16)) u16 (.PCLK(PCLK), .PRESET_n(PRESET_n), .bus(if16));

   assign if8.ss_i = ss;          assign if12.ss_i = ss;          assign if16.ss_i = ss;
   assign if8.start_i = start;    assign if12.start_i = start;    assign if16.start_i = start;
   assign if8.cpha_i = cpha;      assign if12.cpha_i = cpha;      assign if16.cpha_i = cpha;
   assign if8.lsbfe_i = lsbfe;    assign if12.lsbfe_i = lsbfe;    assign if16.lsbfe_i = lsbfe;
   assign if8.frame_len_i = fl[2:0];
   assign if12.frame_len_i = fl;  assign if16.frame_len_i = fl;
   assign if8.launch_i = launch;  assign if12.launch_i = launch;  assign if16.launch_i = launch;
   assign if8.sample_i = sample;  assign if12.sample_i = sample;  assign if16.sample_i = sample;
   assign if8.data_mosi_i = tx[7:0];
   assign if12.data_mosi_i = tx[11:0];
   assign if16.data_mosi_i = tx;
   assign if8.miso_i = miso;      assign if12.miso_i = miso;      assign if16.miso_i = miso;

   logic [2:0]  o_mosi, o_busy, o_rxv, o_abt;
   logic [15:0] o_dm [3];
   assign o_mosi = {if16.mosi_o, if12.mosi_o, if8.mosi_o};
   assign o_busy = {if16.busy_o, if12.busy_o, if8.busy_o};
   assign o_rxv  = {if16.rx_valid_o, if12.rx_valid_o, if8.rx_valid_o};
   assign o_abt  = {if16.abort_o, if12.abort_o, if8.abort_o};
   assign o_dm[0] = {8'd0, if8.data_miso_o};
   assign o_dm[1] = {4'd0, if12.data_miso_o};
   assign o_dm[2] = if16.data_miso_o;

   // Reference model: per width, how many bits were presented / sampled so far.
   bit          m_act [3];
   bit          m_lsb [3];
   int          m_nl  [3];
   int          m_ns  [3];
   int          m_len [3];
   logic [15:0] m_tx  [3];
   logic [15:0] m_rx  [3];
   logic [15:0] e_dm  [3];
   logic        e_mosi [3];
   logic        e_rxv  [3];
   logic        e_abt  [3];

   function automatic int dw_of(int k);
      return (k == 0) ? 8 : ((k == 1) ? 12 : 16);
   endfunction

   function automatic int cw_of(int k);
      return (k == 0) ? 3 : 4;
   endfunction

   function automatic int pos_of(int k, int i);
      return m_lsb[k] ? i : m_len[k] - i;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_act[k] = 0; m_lsb[k] = 0; m_nl[k] = 0; m_ns[k] = 0; m_len[k] = 0;
         m_tx[k] = '0; m_rx[k] = '0; e_dm[k] = '0;
         e_mosi[k] = 1'b0; e_rxv[k] = 1'b0; e_abt[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         bit was_done;
         int f;
         was_done = e_rxv[k];
         e_rxv[k] = 1'b0;
         e_abt[k] = 1'b0;
         if (m_act[k]) begin
            if (ss) begin
               m_act[k] = 0;
               e_abt[k] = 1'b1;
            end else begin
               if (launch && m_nl[k] <= m_len[k]) begin
                  e_mosi[k] = m_tx[k][pos_of(k, m_nl[k])];
                  m_nl[k]++;
               end
               if (sample) begin
                  m_rx[k][pos_of(k, m_ns[k])] = miso;
                  m_ns[k]++;
                  if (m_ns[k] == m_len[k] + 1) begin
                     m_act[k] = 0;
                     e_rxv[k] = 1'b1;
                     e_dm[k]  = m_rx[k];
                  end
               end
            end
         end else if (start && !ss && !was_done) begin
            f = int'(fl) % (1 << cw_of(k));
            m_len[k] = (f > dw_of(k) - 1) ? dw_of(k) - 1 : f;
            m_lsb[k] = lsbfe;
            m_tx[k]  = tx & 16'((1 << dw_of(k)) - 1);
            m_rx[k]  = '0;
            m_ns[k]  = 0;
            m_act[k] = 1;
            if (!cpha) begin
               e_mosi[k] = m_tx[k][pos_of(k, 0)];
               m_nl[k]   = 1;
            end else begin
               m_nl[k] = 0;
            end
         end
      end
   endtask

   // One clock: predict, clock, compare every width against the model.
   task automatic step();
      logic [19:0] obs, exp_v;
      model_step();
      @(posedge PCLK);
      #1;
      launch = 1'b0;
      sample = 1'b0;
      start  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         obs   = {o_busy[k], o_mosi[k], o_rxv[k], o_abt[k], o_dm[k]};
         exp_v = {m_act[k], e_mosi[k], e_rxv[k], e_abt[k], e_dm[k]};
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL cycle dw%0d t=%0t: busy/mosi/rxv/abort/dm got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
                     dw_of(k), $time, obs[19], obs[18], obs[17], obs[16], obs[15:0],
                     exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
         end
      end
   endtask

   task automatic do_frame(input bit lsb, input bit cp, input logic [3:0] f,
                           input logic [15:0] t, input logic [15:0] mpat,
                           input bit both, input int abort_at, input bit mid_start,
                           input bit start_in_done, output logic [15:0] seq);
      int  guard, ns_issued, nl_before;
      bit  ph, mid_done;
      seq = '0;
      ss = 1'b0; lsbfe = lsb; cpha = cp; fl = f; tx = t; start = 1'b1;
      step();
      if (!cp) seq = {seq[14:0], o_mosi[0]};
      tx = 16'($urandom); fl = 4'($urandom); lsbfe = 1'($urandom); cpha = 1'($urandom);
      ph = cp ? 1'b0 : 1'b1;
      guard = 0; ns_issued = 0; mid_done = 0;
      while ((m_act[0] || m_act[1] || m_act[2]) && guard < 300) begin
         guard++;
         if (abort_at >= 0 && ns_issued == abort_at) begin
            ss = 1'b1;
            step();
            ss = 1'b0;
            continue;
         end
         if ($urandom_range(3) == 0) begin
            step();
            continue;
         end
         if (mid_start && !mid_done && ns_issued == 2) begin
            start = 1'b1; tx = ~t; mid_done = 1;
         end
         if (both) begin
            launch = 1'b1; sample = 1'b1;
         end else if (ph == 1'b0) begin
            launch = 1'b1;
         end else begin
            sample = 1'b1;
         end
         if (sample) begin
            miso = mpat[ns_issued];
            ns_issued++;
         end
         ph = ~ph;
         nl_before = m_nl[0];
         step();
         if (m_nl[0] != nl_before) seq = {seq[14:0], o_mosi[0]};
      end
      if (guard >= 300) begin
         total++; bad++;
         $display("FAIL frame_timeout: still busy after %0d cycles, want done", guard);
      end
      if (start_in_done) start = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset();
      #2 PRESET_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({o_busy[k], o_mosi[k], o_rxv[k], o_abt[k], o_dm[k]} !== 20'd0) begin
            bad++;
            $display("FAIL reset_state dw%0d: got %h want 0", dw_of(k),
                     {o_busy[k], o_mosi[k], o_rxv[k], o_abt[k], o_dm[k]});
         end
      end
      model_reset();
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      PRESET_n = 1'b1;
      step();
   endtask

   task automatic test_ss_gate();
      ss = 1'b1; start = 1'b1; tx = 16'hFFFF; cpha = 1'b0;
      step();
      total++;
      if (o_busy !== 3'b000) begin
         bad++;
         $display("FAIL ss_gate_start: busy got %b want 000", o_busy);
      end
      ss = 1'b0;
   endtask

   task automatic test_msb_cpha0();
      logic [15:0] s;
      do_frame(1'b0, 1'b0, 4'd7, 16'h00A5, 16'h003C, 1'b0, -1, 1'b0, 1'b0, s);
      total++;
      if (s[7:0] !== 8'hA5) begin
         bad++; $display("FAIL msb_cpha0_mosi: got %b want 10100101", s[7:0]);
      end
      total++;
      if (o_dm[0] !== 16'h003C) begin
         bad++; $display("FAIL msb_cpha0_rx: got %h want 003c", o_dm[0]);
      end
   endtask

   task automatic test_lsb_cpha1();
      logic [15:0] s, mp;
      mp = 16'($urandom);
      do_frame(1'b1, 1'b1, 4'd7, 16'h00A5, mp, 1'b0, -1, 1'b0, 1'b0, s);
      total++;
      if (s[7:0] !== 8'hA5) begin
         bad++; $display("FAIL lsb_cpha1_mosi: got %b want 10100101", s[7:0]);
      end
      total++;
      if (o_dm[0] !== {8'd0, mp[7:0]}) begin
         bad++; $display("FAIL lsb_cpha1_rx: got %h want %h", o_dm[0], {8'd0, mp[7:0]});
      end
   endtask

   task automatic test_short_frame();
      logic [15:0] s;
      do_frame(1'b0, 1'b0, 4'd4, 16'hFFF3, 16'hFFFF, 1'b0, -1, 1'b0, 1'b0, s);
      total++;
      if (s[4:0] !== 5'b10011) begin
         bad++; $display("FAIL short_mosi: got %b want 10011", s[4:0]);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (o_dm[k] !== 16'h001F) begin
            bad++; $display("FAIL short_rx dw%0d: got %h want 001f", dw_of(k), o_dm[k]);
         end
      end
   endtask

   task automatic test_clamp();
      logic [15:0] s, mp;
      mp = 16'($urandom);
      do_frame(1'b1, 1'b0, 4'd15, 16'($urandom), mp, 1'b0, -1, 1'b0, 1'b0, s);
      total++;
      if (o_dm[1] !== {4'd0, mp[11:0]}) begin
         bad++; $display("FAIL clamp_rx dw12: got %h want %h", o_dm[1], {4'd0, mp[11:0]});
      end
      total++;
      if (o_dm[2] !== mp) begin
         bad++; $display("FAIL clamp_rx dw16: got %h want %h", o_dm[2], mp);
      end
   endtask

   task automatic test_abort();
      logic [15:0] s, prev;
      prev = e_dm[0];
      do_frame(1'b0, 1'b0, 4'd7, 16'($urandom), 16'($urandom), 1'b0, 3, 1'b0, 1'b0, s);
      total++;
      if (o_dm[0] !== prev || o_busy !== 3'b000) begin
         bad++;
         $display("FAIL abort_keep: dm=%h busy=%b want dm=%h busy=000", o_dm[0], o_busy, prev);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] s, mp, want;
      for (int n = 0; n < 2; n++) begin
         mp = 16'($urandom);
         want = '0;
         for (int j = 0; j < 8; j++) want[7 - j] = mp[j];
         do_frame(1'b0, 1'b0, 4'd7, 16'($urandom), mp, 1'b1, -1, 1'b1, 1'b1, s);
         total++;
         if (o_dm[0] !== want) begin
            bad++; $display("FAIL b2b_rx n=%0d: got %h want %h", n, o_dm[0], want);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] s;
      ss = 1'b0; start = 1'b1; fl = 4'd7; tx = 16'hFFFF; cpha = 1'b0; lsbfe = 1'b0;
      step();
      launch = 1'b1; sample = 1'b1; miso = 1'b1;
      step();
      step();
      PRESET_n = 1'b0;
      #2;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({o_busy[k], o_mosi[k], o_rxv[k], o_abt[k], o_dm[k]} !== 20'd0) begin
            bad++;
            $display("FAIL reset_mid dw%0d: got %h want 0", dw_of(k),
                     {o_busy[k], o_mosi[k], o_rxv[k], o_abt[k], o_dm[k]});
         end
      end
      model_reset();
      @(negedge PCLK);
      PRESET_n = 1'b1;
      step();
      do_frame(1'b1, 1'b1, 4'd6, 16'($urandom), 16'($urandom), 1'b0, -1, 1'b0, 1'b0, s);
   endtask

   task automatic test_random();
      logic [15:0] s;
      for (int n = 0; n < 20; n++) begin
         logic [3:0] f;
         bit ms;
         int ab;
         f  = 4'($urandom_range(15));
         ms = (f < 4'd8) && ($urandom_range(3) == 0);
         ab = ($urandom_range(4) == 0) ? int'($urandom_range(int'(f))) : -1;
         do_frame(1'($urandom), 1'($urandom), f, 16'($urandom), 16'($urandom),
                  1'($urandom), ab, ms, 1'b0, s);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ss_gate();
      test_msb_cpha0();
      test_lsb_cpha1();
      test_short_frame();
      test_clamp();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
